// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the instruction/data memory access controller.
// MISALIGNED_SPLIT_EN adds the DBUS2 state used to split misaligned accesses.
package mem_access_ctrl_pkg;

    localparam int unsigned STARVE_LIMIT_DEF = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_IBUS,
        S_DBUS,
        S_DBUS2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_IBUS,
        S_DBUS
    } state_e;
`endif

    function automatic logic f3_ok(input logic we, input logic [2:0] f3);
        logic r;
        if (we) begin
            r = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            r = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return r;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3[1:0])
            2'b01:   r = off[0];
            2'b10:   r = |off;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// mem_lane_gen: byte-enable and write-data steering for store accesses.
// Split accesses shift data across a 64-bit window; half selects the word.
module mem_lane_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic        half_i,
    input  logic        split_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o
);

    logic [3:0]  size_mask;
    logic [31:0] repl;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic        unused_ok;

    assign unused_ok = funct3_i[2];

    always_comb begin
        size_mask = 4'b0000;
        repl      = '0;
        case (funct3_i[1:0])
            2'b00: begin
                size_mask = 4'b0001;
                repl      = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                size_mask = 4'b0011;
                repl      = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                size_mask = 4'b1111;
                repl      = wdata_i;
            end
            default: ;
        endcase
        mask8     = {4'b0000, size_mask} << off_i;
        data64    = {32'h0, wdata_i} << {off_i, 3'b000};
        byte_en_o = half_i ? mask8[7:4] : mask8[3:0];
        if (split_i) begin
            wdata_o = half_i ? data64[63:32] : data64[31:0];
        end else begin
            wdata_o = repl;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction and data ports onto one word bus with starvation guard.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two bus words.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic        oIAck,
    output logic [31:0] oIRdata,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [2:0]  iDFunct3,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWdata,
    output logic        oDAck,
    output logic        oDErr,
    output logic [31:0] oDRdata,
    output logic [1:0]  oDAlign,
    output logic        oBReq,
    output logic        oBWe,
    output logic [31:0] oBAddr,
    output logic [31:0] oBWdata,
    output logic [3:0]  oBByteEn,
    input  logic [31:0] iBRdata,
    input  logic        iBAck
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q;
    logic [31:0]   addr_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   wdat_q;
    logic [31:0]   rdata_q;
    logic [1:0]    align_q;
    logic          iack_q;
    logic          dack_q;
    logic          derr_q;

    logic          ack_any;
    logic          i_req;
    logic          d_req;
    logic          i_pri;
    logic          gnt_i;
    logic          gnt_d;
    logic          d_bad;
    logic          d_split;
    logic          bus_done;
    logic          lane_half;
    logic          lane_split;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wd;
    logic          unused_ok;

`ifdef MISALIGNED_SPLIT_EN
    logic          split_q;
    logic          half_q;
    logic [31:0]   lo_q;
    logic [63:0]   cat;
    logic [31:0]   merged;

    assign cat        = {iBRdata, lo_q};
    assign merged     = cat[{1'b0, off_q, 3'b000} +: 32];
    assign d_split    = f3_misaligned(iDFunct3, iDAddr[1:0]);
    assign d_bad      = !f3_ok(iDWe, iDFunct3);
    assign lane_half  = half_q;
    assign lane_split = split_q;
`else
    assign d_split    = 1'b0;
    assign d_bad      = !f3_ok(iDWe, iDFunct3) ||
                        f3_misaligned(iDFunct3, iDAddr[1:0]);
    assign lane_half  = 1'b0;
    assign lane_split = 1'b0;
`endif

    assign unused_ok = ^{iIAddr[1:0], d_split};

    // The cycle that presents an ack is a turnaround: no new grant.
    assign ack_any  = iack_q | dack_q;
    assign i_req    = iIReq & ~ack_any;
    assign d_req    = iDReq & ~ack_any;
    assign i_pri    = (starve_q == LIM);
    assign gnt_d    = (state_q == S_IDLE) & d_req & ~(i_req & i_pri);
    assign gnt_i    = (state_q == S_IDLE) & i_req & ~gnt_d;
    assign bus_done = (state_q != S_IDLE) & iBAck;

    mem_lane_gen u_lane (
        .funct3_i  (f3_q),
        .off_i     (off_q),
        .half_i    (lane_half),
        .split_i   (lane_split),
        .wdata_i   (wdat_q),
        .byte_en_o (lane_be),
        .wdata_o   (lane_wd)
    );

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_i) begin
                    state_d = S_IBUS;
                end else if (gnt_d && !d_bad) begin
                    state_d = S_DBUS;
                end
            end
            S_IBUS: begin
                if (iBAck) state_d = S_IDLE;
            end
            S_DBUS: begin
`ifdef MISALIGNED_SPLIT_EN
                if (iBAck) state_d = split_q ? S_DBUS2 : S_IDLE;
`else
                if (iBAck) state_d = S_IDLE;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            S_DBUS2: begin
                if (iBAck) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oBReq    = 1'b0;
        oBWe     = 1'b0;
        oBByteEn = 4'h0;
        oBWdata  = '0;
        unique case (state_q)
            S_IBUS: begin
                oBReq    = 1'b1;
                oBByteEn = 4'hF;
            end
`ifdef MISALIGNED_SPLIT_EN
            S_DBUS, S_DBUS2: begin
`else
            S_DBUS: begin
`endif
                oBReq    = 1'b1;
                oBWe     = we_q;
                oBByteEn = we_q ? lane_be : 4'hF;
                oBWdata  = we_q ? lane_wd : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            wdat_q   <= '0;
            rdata_q  <= '0;
            align_q  <= '0;
            iack_q   <= 1'b0;
            dack_q   <= 1'b0;
            derr_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_q  <= 1'b0;
            half_q   <= 1'b0;
            lo_q     <= '0;
`endif
        end else begin
            iack_q <= 1'b0;
            dack_q <= 1'b0;
            derr_q <= 1'b0;
            if (gnt_i) begin
                starve_q <= '0;
                addr_q   <= {iIAddr[31:2], 2'b00};
                we_q     <= 1'b0;
                f3_q     <= F3_LW;
                off_q    <= 2'b00;
`ifdef MISALIGNED_SPLIT_EN
                split_q  <= 1'b0;
                half_q   <= 1'b0;
`endif
            end
            if (gnt_d) begin
                if (i_req && starve_q != LIM) starve_q <= starve_q + 1'b1;
                if (d_bad) begin
                    dack_q <= 1'b1;
                    derr_q <= 1'b1;
                end else begin
                    addr_q <= {iDAddr[31:2], 2'b00};
                    we_q   <= iDWe;
                    f3_q   <= iDFunct3;
                    off_q  <= iDAddr[1:0];
                    wdat_q <= iDWdata;
`ifdef MISALIGNED_SPLIT_EN
                    split_q <= d_split;
                    half_q  <= 1'b0;
`endif
                end
            end
            if (bus_done) begin
                if (state_q == S_IBUS) begin
                    iack_q  <= 1'b1;
                    rdata_q <= iBRdata;
                end
`ifdef MISALIGNED_SPLIT_EN
                else if (state_q == S_DBUS && split_q) begin
                    lo_q   <= iBRdata;
                    addr_q <= addr_q + 32'd4;
                    half_q <= 1'b1;
                end else if (split_q) begin
                    dack_q  <= 1'b1;
                    rdata_q <= merged;
                    align_q <= 2'b00;
                end
`endif
                else begin
                    dack_q  <= 1'b1;
                    rdata_q <= iBRdata;
                    align_q <= we_q ? 2'b00 : off_q;
                end
            end
        end
    end

    assign oBAddr  = addr_q;
    assign oIAck   = iack_q;
    assign oIRdata = rdata_q;
    assign oDAck   = dack_q;
    assign oDErr   = derr_q;
    assign oDRdata = rdata_q;
    assign oDAlign = align_q;

endmodule
